fpu_wb_arbiter: RTL and testbench
=================================

# fpu_wb_arbiter

Parametrised writeback arbiter for the floating-point unit. It collects results from NSRC execution sources (add/sub/mul/div/convert/move units) over per-source valid/ready handshakes and picks one per cycle by round-robin or fixed priority. The winner's result, destination tag and source index go into a single registered output stage with its own valid/ready handshake toward the FP register file. It replaces the decoded-address result multiplexer: sources present results when ready, and no opcode select is needed.

## Interface

Parameters:
- NSRC, 12, number of result sources (2..16)
- DW, 32, result data width
- TAGW, 5, destination register tag width
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- src_valid  in  NSRC  source i presents a result
- src_ready  out  NSRC  source i result accepted this cycle (one-hot or zero)
- src_data  in  NSRC*DW  source i result at bits [i*DW +: DW]
- src_tag  in  NSRC*TAGW  source i destination tag at [i*TAGW +: TAGW]
- wb_valid  out  1  output stage holds a result
- wb_ready  in  1  register file consumes the output this cycle
- wb_data  out  DW  registered result
- wb_tag  out  TAGW  registered destination tag
- wb_src  out  $clog2(NSRC)  index of the source that produced wb_data
- conflict_cnt  out  16  saturating count of cycles with more than one src_valid

## Operation

- Output stage may load when `load_en = !wb_valid || wb_ready`.
- Arbitration is combinational over src_valid and is gated by load_en. src_ready[i] is high only for the granted index, and only when load_en is high. A transfer occurs when src_valid[i] && src_ready[i].
- Round-robin: the search starts at pointer rr_ptr and wraps modulo NSRC. After a transfer from index g, rr_ptr becomes (g+1) mod NSRC. With no transfer, rr_ptr holds.
- Fixed priority: the lowest valid index wins and rr_ptr is unused (held at 0).
- On transfer: wb_data, wb_tag and wb_src load from the winner, and wb_valid goes to 1.
- If wb_ready is high with no new transfer, wb_valid goes to 0. wb_data, wb_tag and wb_src hold their last values.
- Output-stage states:
  - EMPTY (wb_valid=0): goes to FULL on any transfer.
  - FULL (wb_valid=1):
    - with wb_ready and a transfer: stays FULL with the new data (back-to-back).
    - with wb_ready and no transfer: goes to EMPTY.
    - with !wb_ready: stays FULL with all outputs stable, and every src_ready is 0.
- Sources must hold src_valid, src_data and src_tag stable until accepted. The block does not check this.
- conflict_cnt increments when popcount(src_valid) ≥ 2 and saturates at 16'hFFFF.
- Reset mid-operation drops any held result. Sources that were not accepted remain responsible for their data.

## Timing

- Reset values: wb_valid=0, wb_data=0, wb_tag=0, wb_src=0, rr_ptr=0, conflict_cnt=0. src_ready is 0 during the reset cycle.
- Latency: a result accepted on edge N is visible on wb_* after edge N (one cycle).
- Throughput: one result per cycle while wb_ready=1.
- src_ready depends combinationally on src_valid, wb_valid and wb_ready. wb_* outputs are purely registered.
- Fairness: with all NSRC sources continuously valid and wb_ready=1, each source is granted exactly once every NSRC cycles in round-robin mode.

## Structure

- Package fpu_wb_pkg holds:
  - NSRC_DEFAULT and the source index constants: SRC_ADDS=0, SRC_ADDPS, SRC_SUBS, SRC_SUBPS, SRC_MULS, SRC_MULPS, SRC_DIVS, SRC_CVTPSS, SRC_CVT0, SRC_CVTSPL, SRC_CVTSPU, SRC_MTC1=11.
  - PRIO_RR / PRIO_FIXED encodings.
- Sub-module rr_arbiter (parameter N, inputs req, ptr, mode; output one-hot grant plus encoded index). It is pure combinational, and the pointer register lives in the parent.

## Test plan

- Reset, then src_valid[4]=1 with data 32'h3F800000 and tag 5'd7, wb_ready=1: one cycle later wb_valid=1, wb_data=32'h3F800000, wb_tag=7, wb_src=4. After the next edge wb_valid=0.
- All 12 sources valid continuously, wb_ready=1, round-robin mode: wb_src sequence is 0,1,…,11,0. conflict_cnt increments every cycle.
- Same stimulus with PRIO_MODE=1: wb_src stays 0 and sources 1..11 never see src_ready.
- wb_ready held 0 for 3 cycles while FULL: wb_* stay stable and all src_ready stay 0. Raising wb_ready with source 2 valid gives a back-to-back load with wb_src=2.
- rst asserted while FULL with source 9 pending: next cycle wb_valid=0, rr_ptr=0 and conflict_cnt=0. After rst is released, source 9 is accepted.
- Saturation: force 70000 conflict cycles; conflict_cnt ends at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/fpu_wb_pkg.sv
// Shared constants for the FP writeback arbiter: source indices, arbitration modes, output-stage state.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fpu_wb_pkg;

    localparam int NSRC_DEFAULT = 12;

    // Execution-unit result sources, in their fixed-priority order
    localparam int SRC_ADDS   = 0;
    localparam int SRC_ADDPS  = 1;
    localparam int SRC_SUBS   = 2;
    localparam int SRC_SUBPS  = 3;
    localparam int SRC_MULS   = 4;
    localparam int SRC_MULPS  = 5;
    localparam int SRC_DIVS   = 6;
    localparam int SRC_CVTPSS = 7;
    localparam int SRC_CVT0   = 8;
    localparam int SRC_CVTSPL = 9;
    localparam int SRC_CVTSPU = 10;
    localparam int SRC_MTC1   = 11;

    // Arbitration modes
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Output-stage occupancy
    typedef enum logic {
        WB_EMPTY = 1'b0,
        WB_FULL  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/fpu_wb_rr_arbiter.sv
// Combinational arbiter: round-robin search from ptr (mode=0) or lowest-index-first (mode=1).
// Latency: zero cycles, purely combinational; the pointer register lives in the parent.
// Backpressure: none here; the parent gates the grant with its own load enable.
//   req   : request vector
//   ptr   : round-robin start index (ignored when mode=1)
//   mode  : 0 = round-robin, 1 = fixed priority
//   grant : one-hot grant (zero when no request)
//   idx   : encoded index of the granted request
//   any   : at least one request present
module rr_arbiter #(
    parameter int N  = 12,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] start;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    assign start = mode ? '0 : ptr;

    // Walk every offset from the start point, wrapping modulo N; the first
    // requester found wins. The extra sum bit keeps ptr+k from overflowing.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, start} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_wb_arbiter.sv
// FP writeback arbiter: picks one of NSRC execution results per cycle into a registered output stage.
// Latency: one cycle from src accept to wb_* valid; one result per cycle while wb_ready=1.
// Backpressure: wb_ready low while full holds wb_* stable and forces every src_ready to 0.
//   clk, rst          : clock, synchronous active-high reset
//   src_valid/ready   : per-source handshake (src_ready one-hot or zero)
//   src_data, src_tag : per-source result and destination tag, packed by source index
//   wb_valid/ready    : output-stage handshake toward the FP register file
//   wb_data/tag/src   : registered result, tag and producing source index
//   conflict_cnt      : saturating count of cycles with two or more sources valid
module fpu_wb_arbiter
    import fpu_wb_pkg::*;
#(
    parameter int NSRC      = NSRC_DEFAULT,
    parameter int DW        = 32,
    parameter int TAGW      = 5,
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         src_valid,
    output logic [NSRC-1:0]         src_ready,
    input  logic [NSRC*DW-1:0]      src_data,
    input  logic [NSRC*TAGW-1:0]    src_tag,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [DW-1:0]           wb_data,
    output logic [TAGW-1:0]         wb_tag,
    output logic [$clog2(NSRC)-1:0] wb_src,
    output logic [15:0]             conflict_cnt
);

    localparam int  SW    = $clog2(NSRC);
    localparam logic FIXED = (PRIO_MODE == PRIO_FIXED);

    wb_state_e       state;
    logic [SW-1:0]   rr_ptr;
    logic [NSRC-1:0] grant;
    logic [SW-1:0]   gnt_idx;
    logic            gnt_any;
    logic            load_en;
    logic            xfer;
    logic            multi;
    logic [DW-1:0]   sel_data;
    logic [TAGW-1:0] sel_tag;

    rr_arbiter #(
        .N  (NSRC),
        .PW (SW)
    ) u_arb (
        .req   (src_valid),
        .ptr   (rr_ptr),
        .mode  (FIXED),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign wb_valid = (state == WB_FULL);
    assign load_en  = !wb_valid || wb_ready;

    // Grants are held off during reset so no source believes it was accepted
    // by a stage that is about to be cleared.
    assign src_ready = (load_en && !rst) ? grant : '0;
    assign xfer      = load_en && !rst && gnt_any;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi = |(src_valid & (src_valid - NSRC'(1)));

    always_comb begin
        sel_data = '0;
        sel_tag  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_idx == SW'(i)) begin
                sel_data = src_data[i*DW +: DW];
                sel_tag  = src_tag[i*TAGW +: TAGW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WB_EMPTY;
            wb_data      <= '0;
            wb_tag       <= '0;
            wb_src       <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (multi && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end

            // Payload only moves on a transfer; on drain it keeps its last value.
            if (xfer) begin
                wb_data <= sel_data;
                wb_tag  <= sel_tag;
                wb_src  <= gnt_idx;
                if (!FIXED) begin
                    rr_ptr <= (gnt_idx == SW'(NSRC-1)) ? '0 : gnt_idx + SW'(1);
                end
            end

            case (state)
                WB_EMPTY: begin
                    if (xfer) begin
                        state <= WB_FULL;
                    end
                end
                WB_FULL: begin
                    // wb_ready with a new transfer stays FULL (back-to-back);
                    // !wb_ready blocks xfer entirely, so state simply holds.
                    if (wb_ready && !xfer) begin
                        state <= WB_EMPTY;
                    end
                end
                default: state <= WB_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed bench for fpu_wb_arbiter: a round-robin and a fixed-priority instance share one stimulus.
// Latency: checks one-cycle accept-to-output timing.
// Backpressure: checks src_ready gating and wb_* stability while wb_ready is low.
module tb_fpu_wb_arbiter;

    localparam int NSRC = 12;
    localparam int DW   = 32;
    localparam int TAGW = 5;

    logic                 clk;
    logic                 rst;
    logic [NSRC-1:0]      src_valid;
    logic [NSRC*DW-1:0]   src_data;
    logic [NSRC*TAGW-1:0] src_tag;
    logic                 wb_ready;

    logic [NSRC-1:0] src_ready;
    logic            wb_valid;
    logic [DW-1:0]   wb_data;
    logic [TAGW-1:0] wb_tag;
    logic [3:0]      wb_src;
    logic [15:0]     conflict_cnt;

    logic [NSRC-1:0] src_ready_fp;
    logic            wb_valid_fp;
    logic [DW-1:0]   wb_data_fp;
    logic [TAGW-1:0] wb_tag_fp;
    logic [3:0]      wb_src_fp;
    logic [15:0]     conflict_cnt_fp;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_wb_arbiter #(.NSRC(NSRC), .DW(DW), .TAGW(TAGW), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .src_tag(src_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_tag(wb_tag), .wb_src(wb_src),
        .conflict_cnt(conflict_cnt)
    );

    fpu_wb_arbiter #(.NSRC(NSRC), .DW(DW), .TAGW(TAGW), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready_fp),
        .src_data(src_data), .src_tag(src_tag),
        .wb_valid(wb_valid_fp), .wb_ready(wb_ready),
        .wb_data(wb_data_fp), .wb_tag(wb_tag_fp), .wb_src(wb_src_fp),
        .conflict_cnt(conflict_cnt_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; registered outputs are
    // read there too, combinational outputs at the following falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_src(input int idx, input logic [DW-1:0] d, input logic [TAGW-1:0] t);
        src_data[idx*DW +: DW]   = d;
        src_tag[idx*TAGW +: TAGW] = t;
    endtask

    task automatic init_srcs();
        for (int i = 0; i < NSRC; i++) begin
            set_src(i, 32'h4000_0000 + DW'(i), TAGW'(i + 16));
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        src_valid = '0;
        wb_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        src_valid = '1;
        wb_ready  = 1'b1;
        mid();
        n_checks++; if (src_ready !== 12'h000) begin n_fail++; $display("FAIL reset_src_ready: got %h want 000", src_ready); end
        n_checks++; if (src_ready_fp !== 12'h000) begin n_fail++; $display("FAIL reset_src_ready_fp: got %h want 000", src_ready_fp); end
        step();
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
        n_checks++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
        n_checks++; if (wb_tag !== 5'd0) begin n_fail++; $display("FAIL reset_wb_tag: got %0d want 0", wb_tag); end
        n_checks++; if (wb_src !== 4'd0) begin n_fail++; $display("FAIL reset_wb_src: got %0d want 0", wb_src); end
        n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_conflict: got %0d want 0", conflict_cnt); end
        n_checks++; if (dut.rr_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr); end
        src_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_src(4, 32'h3F80_0000, 5'd7);
        src_valid = 12'h010;
        wb_ready  = 1'b1;
        mid();
        n_checks++; if (src_ready !== 12'h010) begin n_fail++; $display("FAIL single_src_ready: got %h want 010", src_ready); end
        step();
        src_valid = '0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_wb_data: got %h want 3f800000", wb_data); end
        n_checks++; if (wb_tag !== 5'd7) begin n_fail++; $display("FAIL single_wb_tag: got %0d want 7", wb_tag); end
        n_checks++; if (wb_src !== 4'd4) begin n_fail++; $display("FAIL single_wb_src: got %0d want 4", wb_src); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b want 0", wb_valid); end
        n_checks++; if (wb_data !== 32'h3F80_0000) begin n_fail++; $display("FAIL single_drain_hold: got %h want 3f800000", wb_data); end
        n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL single_conflict: got %0d want 0", conflict_cnt); end
    endtask

    task automatic test_round_robin();
        logic [NSRC-1:0] exp_rdy;
        int              s;
        do_reset();
        init_srcs();
        src_valid = '1;
        wb_ready  = 1'b1;
        for (int k = 0; k < 13; k++) begin
            s       = k % NSRC;
            exp_rdy = NSRC'(1) << s;
            mid();
            n_checks++; if (src_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_src_ready[%0d]: got %h want %h", k, src_ready, exp_rdy); end
            n_checks++; if (src_ready_fp !== 12'h001) begin n_fail++; $display("FAIL fp_src_ready[%0d]: got %h want 001", k, src_ready_fp); end
            step();
            n_checks++; if (wb_src !== 4'(s)) begin n_fail++; $display("FAIL rr_wb_src[%0d]: got %0d want %0d", k, wb_src, s); end
            n_checks++; if (wb_data !== 32'h4000_0000 + 32'(s)) begin n_fail++; $display("FAIL rr_wb_data[%0d]: got %h want %h", k, wb_data, 32'h4000_0000 + 32'(s)); end
            n_checks++; if (conflict_cnt !== 16'(k + 1)) begin n_fail++; $display("FAIL rr_conflict[%0d]: got %0d want %0d", k, conflict_cnt, k + 1); end
            n_checks++; if (wb_src_fp !== 4'd0) begin n_fail++; $display("FAIL fp_wb_src[%0d]: got %0d want 0", k, wb_src_fp); end
            n_checks++; if (wb_valid_fp !== 1'b1) begin n_fail++; $display("FAIL fp_wb_valid[%0d]: got %b want 1", k, wb_valid_fp); end
        end
        src_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        init_srcs();
        wb_ready  = 1'b1;
        src_valid = 12'h001;
        step();
        src_valid = 12'h004;
        wb_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            n_checks++; if (src_ready !== 12'h000) begin n_fail++; $display("FAIL stall_src_ready[%0d]: got %h want 000", k, src_ready); end
            step();
            n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL stall_wb_valid[%0d]: got %b want 1", k, wb_valid); end
            n_checks++; if (wb_data !== 32'h4000_0000) begin n_fail++; $display("FAIL stall_wb_data[%0d]: got %h want 40000000", k, wb_data); end
            n_checks++; if (wb_src !== 4'd0) begin n_fail++; $display("FAIL stall_wb_src[%0d]: got %0d want 0", k, wb_src); end
            n_checks++; if (wb_tag !== 5'd16) begin n_fail++; $display("FAIL stall_wb_tag[%0d]: got %0d want 16", k, wb_tag); end
        end
        wb_ready = 1'b1;
        mid();
        n_checks++; if (src_ready !== 12'h004) begin n_fail++; $display("FAIL b2b_src_ready: got %h want 004", src_ready); end
        step();
        src_valid = '0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_wb_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_src !== 4'd2) begin n_fail++; $display("FAIL b2b_wb_src: got %0d want 2", wb_src); end
        n_checks++; if (wb_data !== 32'h4000_0002) begin n_fail++; $display("FAIL b2b_wb_data: got %h want 40000002", wb_data); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", wb_valid); end
        n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_conflict: got %0d want 0", conflict_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        init_srcs();
        wb_ready  = 1'b0;
        src_valid = 12'h001;
        step();
        src_valid = 12'h600;
        step();
        step();
        n_checks++; if (conflict_cnt !== 16'd2) begin n_fail++; $display("FAIL rmid_conflict_pre: got %0d want 2", conflict_cnt); end
        n_checks++; if (dut.rr_ptr !== 4'd1) begin n_fail++; $display("FAIL rmid_rr_ptr_pre: got %0d want 1", dut.rr_ptr); end
        rst       = 1'b1;
        src_valid = 12'h200;
        mid();
        n_checks++; if (src_ready !== 12'h000) begin n_fail++; $display("FAIL rmid_src_ready_rst: got %h want 000", src_ready); end
        step();
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_wb_valid: got %b want 0", wb_valid); end
        n_checks++; if (dut.rr_ptr !== 4'd0) begin n_fail++; $display("FAIL rmid_rr_ptr: got %0d want 0", dut.rr_ptr); end
        n_checks++; if (conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_conflict: got %0d want 0", conflict_cnt); end
        rst      = 1'b0;
        wb_ready = 1'b1;
        mid();
        n_checks++; if (src_ready !== 12'h200) begin n_fail++; $display("FAIL rmid_src9_ready: got %h want 200", src_ready); end
        step();
        src_valid = '0;
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_src9_valid: got %b want 1", wb_valid); end
        n_checks++; if (wb_src !== 4'd9) begin n_fail++; $display("FAIL rmid_src9_src: got %0d want 9", wb_src); end
        n_checks++; if (wb_data !== 32'h4000_0009) begin n_fail++; $display("FAIL rmid_src9_data: got %h want 40000009", wb_data); end
        n_checks++; if (dut.rr_ptr !== 4'd10) begin n_fail++; $display("FAIL rmid_rr_ptr_post: got %0d want 10", dut.rr_ptr); end
    endtask

    task automatic test_saturation();
        do_reset();
        init_srcs();
        src_valid = '1;
        wb_ready  = 1'b1;
        repeat (65534) step();
        n_checks++; if (conflict_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_before: got %h want fffe", conflict_cnt); end
        step();
        n_checks++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", conflict_cnt); end
        repeat (4465) step();
        n_checks++; if (conflict_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", conflict_cnt); end
        n_checks++; if (conflict_cnt_fp !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold_fp: got %h want ffff", conflict_cnt_fp); end
        src_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        src_valid = '0;
        src_data  = '0;
        src_tag   = '0;
        wb_ready  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
